// File: rtl/down_counter_timer.sv
// Loadable down counter/timer with prescaler, one-shot or auto-reload.
// Q counts to 0 and tc_pulse strobes once per terminal count.
module down_counter_timer #(
  parameter int BITS     = 4,
  parameter int PRESCALE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic            start,
  input  logic            stop,
  input  logic            auto_reload,
  output logic [BITS-1:0] Q,
  output logic            busy,
  output logic            zero,
  output logic            tc_pulse
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [BITS-1:0] q_n;
  logic [BITS-1:0] reload_reg, reload_n;
  logic [PW-1:0]   ps, ps_n;
  logic            tc_n;
  logic            tick;

  assign tick = (ps == PS_LAST);
  assign busy = (state == RUN);
  assign zero = (Q == '0);

  always_comb begin
    state_n  = state;
    q_n      = Q;
    reload_n = reload_reg;
    ps_n     = ps;
    tc_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          q_n      = load_val;
          reload_n = load_val;
        end else if (start && Q != '0) begin
          state_n = RUN;
          ps_n    = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (load) begin
          q_n      = load_val;
          reload_n = load_val;
          ps_n     = '0;
          if (load_val == '0)
            state_n = DONE;
        end else begin
          ps_n = tick ? '0 : ps + PW'(1);
          if (tick) begin
            if (Q > BITS'(1)) begin
              q_n = Q - BITS'(1);
            end else begin
              tc_n = 1'b1;
              // auto_reload only matters on this terminal tick
              if (auto_reload) begin
                q_n = reload_reg;
              end else begin
                q_n     = '0;
                state_n = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        if (load) begin
          q_n      = load_val;
          reload_n = load_val;
          state_n  = IDLE;
        end else if (start && reload_reg != '0) begin
          q_n     = reload_reg;
          state_n = RUN;
          ps_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      Q          <= '0;
      reload_reg <= '0;
      ps         <= '0;
      tc_pulse   <= 1'b0;
    end else begin
      state      <= state_n;
      Q          <= q_n;
      reload_reg <= reload_n;
      ps         <= ps_n;
      tc_pulse   <= tc_n;
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios plus random
// stimulus against a count-arithmetic reference model.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;

  logic [3:0] q1, q3;
  logic       busy1, zero1, tc1;
  logic       busy3, zero3, tc3;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.BITS(4), .PRESCALE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .Q(q1), .busy(busy1), .zero(zero1), .tc_pulse(tc1)
  );

  down_counter_timer #(.BITS(4), .PRESCALE(3)) u3 (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .Q(q3), .busy(busy3), .zero(zero3), .tc_pulse(tc3)
  );

  // model: 0 idle, 1 run, 2 done; el = clk cycles spent running
  int mq[2], mrel[2], mst[2], mel[2], mtc[2];

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    load = 0; start = 0; stop = 0; auto_reload = 0; load_val = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tk();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mrel[k] = 0; mst[k] = 0; mel[k] = 0; mtc[k] = 0;
    end
  endtask

  task automatic model_step(int k, int p);
    int lv;
    lv = int'(load_val);
    mtc[k] = 0;
    case (mst[k])
      0: begin
        if (load) begin
          mq[k] = lv; mrel[k] = lv;
        end else if (start && mq[k] != 0) begin
          mst[k] = 1; mel[k] = 0;
        end
      end
      1: begin
        if (stop) begin
          mst[k] = 0;
        end else if (load) begin
          mq[k] = lv; mrel[k] = lv; mel[k] = 0;
          if (lv == 0) mst[k] = 2;
        end else begin
          mel[k]++;
          if (mel[k] % p == 0) begin
            if (mq[k] > 1) begin
              mq[k]--;
            end else begin
              mtc[k] = 1;
              if (auto_reload) mq[k] = mrel[k];
              else begin mq[k] = 0; mst[k] = 2; end
            end
          end
        end
      end
      default: begin
        if (load) begin
          mq[k] = lv; mrel[k] = lv; mst[k] = 0;
        end else if (start && mrel[k] != 0) begin
          mq[k] = mrel[k]; mst[k] = 1; mel[k] = 0;
        end
      end
    endcase
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_chk++;
    if ({q1, busy1, zero1, tc1} !== 7'b0000_0_1_0)
      $display("FAIL reset_u1 got q=%0d b=%0b z=%0b tc=%0b want q=0 b=0 z=1 tc=0",
               q1, busy1, zero1, tc1);
    else n_pass++;
    n_chk++;
    if ({q3, busy3, zero3, tc3} !== 7'b0000_0_1_0)
      $display("FAIL reset_u3 got q=%0d b=%0b z=%0b tc=%0b want q=0 b=0 z=1 tc=0",
               q3, busy3, zero3, tc3);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_oneshot();
    load_val = 4'd5; load = 1;
    tk();
    load = 0; start = 1;
    tk();
    start = 0;
    n_chk++;
    if (q1 !== 4'd5 || busy1 !== 1'b1)
      $display("FAIL os_start got q=%0d b=%0b want q=5 b=1", q1, busy1);
    else n_pass++;
    for (int k = 4; k >= 0; k--) begin
      tk();
      n_chk++;
      if (q1 !== 4'(k) || tc1 !== (k == 0) || busy1 !== (k != 0) || zero1 !== (k == 0))
        $display("FAIL os_q%0d got q=%0d tc=%0b b=%0b z=%0b want q=%0d tc=%0b b=%0b",
                 k, q1, tc1, busy1, zero1, k, k == 0, k != 0);
      else n_pass++;
    end
    tk();
    n_chk++;
    if (tc1 !== 1'b0 || q1 !== 4'd0)
      $display("FAIL os_tc_width got tc=%0b q=%0d want tc=0 q=0", tc1, q1);
    else n_pass++;
  endtask

  task automatic test_restart();
    start = 1;
    tk();
    start = 0;
    n_chk++;
    if (q1 !== 4'd5 || busy1 !== 1'b1)
      $display("FAIL rs_start got q=%0d b=%0b want q=5 b=1", q1, busy1);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      tk();
      n_chk++;
      if (q1 !== 4'(5 - i) || tc1 !== (i == 5))
        $display("FAIL rs_c%0d got q=%0d tc=%0b want q=%0d tc=%0b",
                 i, q1, tc1, 5 - i, i == 5);
      else n_pass++;
    end
  endtask

  task automatic test_auto_reload();
    auto_reload = 1; load_val = 4'd3; load = 1;
    tk();
    load = 0; start = 1;
    tk();
    start = 0;
    for (int i = 1; i <= 9; i++) begin
      tk();
      n_chk++;
      if (q1 !== 4'(3 - (i % 3)) || tc1 !== (i % 3 == 0) || busy1 !== 1'b1)
        $display("FAIL ar_c%0d got q=%0d tc=%0b b=%0b want q=%0d tc=%0b b=1",
                 i, q1, tc1, busy1, 3 - (i % 3), i % 3 == 0);
      else n_pass++;
    end
    stop = 1;
    tk();
    stop = 0; auto_reload = 0;
  endtask

  task automatic test_pause();
    load_val = 4'd9; load = 1;
    tk();
    load = 0; start = 1;
    tk();
    start = 0;
    tk(); tk(); tk();
    n_chk++;
    if (q1 !== 4'd6)
      $display("FAIL pz_pre got q=%0d want 6", q1);
    else n_pass++;
    stop = 1;
    tk();
    stop = 0;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (q1 !== 4'd6 || busy1 !== 1'b0 || tc1 !== 1'b0)
        $display("FAIL pz_hold%0d got q=%0d b=%0b tc=%0b want q=6 b=0 tc=0",
                 i, q1, busy1, tc1);
      else n_pass++;
      tk();
    end
    start = 1;
    tk();
    start = 0;
    for (int k = 5; k >= 4; k--) begin
      tk();
      n_chk++;
      if (q1 !== 4'(k) || busy1 !== 1'b1)
        $display("FAIL pz_res%0d got q=%0d b=%0b want q=%0d b=1", k, q1, busy1, k);
      else n_pass++;
    end
  endtask

  task automatic test_prescale();
    do_reset();
    load_val = 4'd2; load = 1;
    tk();
    load = 0; start = 1;
    tk();
    start = 0;
    for (int c = 1; c <= 6; c++) begin
      tk();
      n_chk++;
      if (q3 !== 4'((c < 3) ? 2 : (c < 6) ? 1 : 0) || tc3 !== (c == 6))
        $display("FAIL ps_c%0d got q=%0d tc=%0b want q=%0d tc=%0b",
                 c, q3, tc3, (c < 3) ? 2 : (c < 6) ? 1 : 0, c == 6);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_val = 4'd9; load = 1;
    tk();
    load = 0; start = 1;
    tk();
    start = 0;
    tk(); tk();
    n_chk++;
    if (q1 !== 4'd7)
      $display("FAIL ar_pre got q=%0d want 7", q1);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({q1, busy1, zero1, tc1} !== 7'b0000_0_1_0)
      $display("FAIL async_rst got q=%0d b=%0b z=%0b tc=%0b want q=0 b=0 z=1 tc=0",
               q1, busy1, zero1, tc1);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    start = 1;
    tk();
    start = 0;
    tk();
    n_chk++;
    if (busy1 !== 1'b0 || q1 !== 4'd0 || tc1 !== 1'b0)
      $display("FAIL start_q0 got b=%0b q=%0d tc=%0b want b=0 q=0 tc=0",
               busy1, q1, tc1);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      load     = ($urandom_range(15) == 0);
      load_val = 4'($urandom_range(15));
      start    = ($urandom_range(5) == 0);
      stop     = ($urandom_range(13) == 0);
      if ($urandom_range(20) == 0) auto_reload = ~auto_reload;
      @(posedge clk);
      model_step(0, 1);
      model_step(1, 3);
      #1;
      n_chk++;
      if (q1 !== 4'(mq[0]) || busy1 !== (mst[0] == 1) ||
          zero1 !== (mq[0] == 0) || tc1 !== (mtc[0] == 1))
        $display("FAIL rnd_u1 c%0d got q=%0d b=%0b z=%0b tc=%0b want q=%0d b=%0b tc=%0d",
                 c, q1, busy1, zero1, tc1, mq[0], mst[0] == 1, mtc[0]);
      else n_pass++;
      n_chk++;
      if (q3 !== 4'(mq[1]) || busy3 !== (mst[1] == 1) ||
          zero3 !== (mq[1] == 0) || tc3 !== (mtc[1] == 1))
        $display("FAIL rnd_u3 c%0d got q=%0d b=%0b z=%0b tc=%0b want q=%0d b=%0b tc=%0d",
                 c, q3, busy3, zero3, tc3, mq[1], mst[1] == 1, mtc[1]);
      else n_pass++;
    end
    load = 0; start = 0; stop = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_restart();
    test_auto_reload();
    test_pause();
    test_prescale();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
